// File: rtl/simple_accum.sv
// Two-stage signed accumulator of 2*a - b with wrap or saturate on overflow.
// Latency 2 cycles; a held result stalls both stages and drops in_ready.
module simple_accum #(
  parameter int IN_SIZE  = 4,
  parameter int OUT_SIZE = 8,
  parameter int SAT      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_SIZE-1:0]  a,
  input  logic [IN_SIZE-1:0]  b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_SIZE-1:0] o,
  output logic                ovf
);

  localparam int TW = IN_SIZE + 2;
  localparam logic [OUT_SIZE-1:0] MAX_VAL = {1'b0, {(OUT_SIZE-1){1'b1}}};
  localparam logic [OUT_SIZE-1:0] MIN_VAL = {1'b1, {(OUT_SIZE-1){1'b0}}};

  logic                       stall;
  logic                       s1_valid;
  logic signed [TW-1:0]       s1_term;
  logic signed [TW-1:0]       term_c;
  logic signed [OUT_SIZE-1:0] acc;
  logic signed [OUT_SIZE:0]   sum_c;
  logic                       ovf_c;
  logic [OUT_SIZE-1:0]        next_c;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign o        = acc;

  // Both operands zero-extended so 2*a - b never loses its sign bit.
  assign term_c = $signed({1'b0, a, 1'b0}) - $signed({2'b00, b});

  assign sum_c = $signed({acc[OUT_SIZE-1], acc})
               + $signed({{(OUT_SIZE+1-TW){s1_term[TW-1]}}, s1_term});

  assign ovf_c = sum_c[OUT_SIZE] != sum_c[OUT_SIZE-1];

  always_comb begin
    next_c = sum_c[OUT_SIZE-1:0];
    if (ovf_c && (SAT != 0)) begin
      next_c = sum_c[OUT_SIZE] ? MIN_VAL : MAX_VAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_term   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      s1_valid  <= 1'b0;
      s1_term   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_term <= term_c;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        acc <= next_c;
        if (ovf_c) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_accum.sv
// Scoreboard bench: wrap and saturate instances share stimulus, each has its own expected queue.
module tb_simple_accum;

  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, out_ready;
  logic [3:0] a, b;
  logic       in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [7:0] o0, o1;

  int tests = 0;
  int fails = 0;

  typedef struct { int o; int v; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  simple_accum #(.IN_SIZE(4), .OUT_SIZE(8), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .o(o0), .ovf(ovf0));

  simple_accum #(.IN_SIZE(4), .OUT_SIZE(8), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .o(o1), .ovf(ovf1));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offer one beat and wait (bounded) for acceptance; expected results queued on acceptance.
  task automatic send(input logic [3:0] aa, input logic [3:0] bb,
                      input int e0, input int v0, input int e1, input int v1, input bit push);
    bit ok;
    exp_t x;
    ok = 1'b0;
    @(negedge clk);
    a = aa; b = bb; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (in_ready0) begin
        @(posedge clk);
        ok = 1'b1;
        if (push) begin
          x.o = e0; x.v = v0; q0.push_back(x);
          x.o = e1; x.v = v1; q1.push_back(x);
        end
      end else begin
        @(negedge clk);
      end
    end
    #1 in_valid = 1'b0;
    chk("accept_timeout", int'(ok), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    chk("drain", q0.size() + q1.size(), 0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  always @(negedge clk) begin
    exp_t x;
    #2;
    if (rst_n && !clr && out_valid0 && out_ready) begin
      if (q0.size() == 0) chk("wrap_unexpected_result", 1, 0);
      else begin
        x = q0.pop_front();
        chk("wrap_o", int'($signed(o0)), x.o);
        chk("wrap_ovf", int'(ovf0), x.v);
      end
    end
    if (rst_n && !clr && out_valid1 && out_ready) begin
      if (q1.size() == 0) chk("sat_unexpected_result", 1, 0);
      else begin
        x = q1.pop_front();
        chk("sat_o", int'($signed(o1)), x.o);
        chk("sat_ovf", int'(ovf1), x.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    chk("rst_o", int'(o0), 0);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_ovf", int'(ovf1), 0);
    chk("rst_in_ready", int'(in_ready0), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single beat, latency and out_valid pulse
    send(4'd3, 4'd1, 5, 0, 5, 0, 1'b1);
    @(negedge clk); #1 chk("lat_edge1_valid", int'(out_valid0), 0);
    @(negedge clk); #1 chk("lat_edge2_valid", int'(out_valid0), 1);
    @(negedge clk); #1 chk("pulse_drop_valid", int'(out_valid0), 0);
    chk("acc_retained", int'($signed(o0)), 5);
    drain();

    // back-to-back beats at full throughput
    do_clr();
    send(4'd3, 4'd1, 5, 0, 5, 0, 1'b1);
    send(4'd0, 4'd4, 1, 0, 1, 0, 1'b1);
    send(4'd7, 4'd2, 13, 0, 13, 0, 1'b1);
    @(negedge clk); #1 chk("b2b_valid_a", int'(out_valid0), 1);
    @(negedge clk); #1 chk("b2b_valid_b", int'(out_valid0), 1);
    @(negedge clk); #1 chk("b2b_valid_c", int'(out_valid0), 0);
    drain();

    // positive overflow: wrap vs clamp
    do_clr();
    send(4'd15, 4'd0, 30, 0, 30, 0, 1'b1);
    send(4'd15, 4'd0, 60, 0, 60, 0, 1'b1);
    send(4'd15, 4'd0, 90, 0, 90, 0, 1'b1);
    send(4'd15, 4'd0, 120, 0, 120, 0, 1'b1);
    send(4'd15, 4'd0, -106, 1, 127, 1, 1'b1);
    drain();

    // negative overflow then recovery with sticky ovf
    do_clr();
    for (int k = 1; k <= 8; k++) send(4'd0, 4'd15, -15 * k, 0, -15 * k, 0, 1'b1);
    send(4'd0, 4'd15, 121, 1, -128, 1, 1'b1);
    send(4'd15, 4'd0, -105, 1, -98, 1, 1'b1);
    drain();

    // clr beats a held result and an offered beat
    @(negedge clk); out_ready = 1'b0;
    send(4'd1, 4'd0, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("preclr_valid", int'(out_valid0), 1);
    chk("preclr_ovf", int'(ovf0), 1);
    a = 4'd7; b = 4'd7; in_valid = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0; in_valid = 1'b0;
    chk("clr_o_wrap", int'(o0), 0);
    chk("clr_o_sat", int'(o1), 0);
    chk("clr_valid", int'(out_valid0), 0);
    chk("clr_ovf_wrap", int'(ovf0), 0);
    chk("clr_ovf_sat", int'(ovf1), 0);
    q0.delete(); q1.delete();
    out_ready = 1'b1;
    send(4'd3, 4'd1, 5, 0, 5, 0, 1'b1);
    drain();

    // stall holds the pipeline, nothing lost or duplicated on release
    do_clr();
    out_ready = 1'b0;
    send(4'd1, 4'd0, 2, 0, 2, 0, 1'b1);
    send(4'd2, 4'd1, 5, 0, 5, 0, 1'b1);
    @(negedge clk);
    a = 4'd3; b = 4'd0; in_valid = 1'b1;
    #1 chk("stall_in_ready", int'(in_ready0), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("stall_in_ready_held", int'(in_ready1), 0);
      chk("stall_o_held", int'($signed(o0)), 2);
      chk("stall_valid_held", int'(out_valid0), 1);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    send(4'd3, 4'd0, 11, 0, 11, 0, 1'b1);
    drain();

    // asynchronous reset mid-stream drops in-flight beats
    send(4'd1, 4'd1, 0, 0, 0, 0, 1'b0);
    send(4'd2, 4'd1, 0, 0, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_o", int'(o0), 0);
    chk("arst_valid", int'(out_valid1), 0);
    chk("arst_in_ready", int'(in_ready0), 1);
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(4'd3, 4'd1, 5, 0, 5, 0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
